// File: rtl/fifo_ctrl_flex.sv
// Pointer, occupancy and status controller for a single-clock FIFO of arbitrary depth.
// The data RAM is external; this block only decides which accesses happen and where.
module fifo_ctrl_flex #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1),
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH-1:0] LastPtr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  DepthC  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  AfC     = CNT_WIDTH'(AF_THRESH);
  localparam logic [CNT_WIDTH-1:0]  AeC     = CNT_WIDTH'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wPtr_q, wPtr_d;
  logic [ADDR_WIDTH-1:0] rPtr_q, rPtr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almostFull_q, almostFull_d;
  logic                  almostEmpty_q, almostEmpty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  // A write into a full FIFO is legal when a read frees the slot in the same cycle.
  assign r_en = rd & ~empty_q & ~clr;
  assign w_en = wr & ~clr & (~full_q | rd);

  always_comb begin
    wPtr_d        = w_en ? ((wPtr_q == LastPtr) ? '0 : wPtr_q + 1'b1) : wPtr_q;
    rPtr_d        = r_en ? ((rPtr_q == LastPtr) ? '0 : rPtr_q + 1'b1) : rPtr_q;
    count_d       = count_q + CNT_WIDTH'(w_en) - CNT_WIDTH'(r_en);
    full_d        = (count_d == DepthC);
    empty_d       = (count_d == '0);
    almostFull_d  = (count_d >= AfC);
    almostEmpty_d = (count_d <= AeC);
    overflow_d    = overflow_q | (wr & ~w_en & ~clr);
    underflow_d   = underflow_q | (rd & ~r_en & ~clr);
  end

  // Flush behaves exactly like reset so no stale contents or error history survive it.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wPtr_q        <= '0;
      rPtr_q        <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almostFull_q  <= 1'b0;
      almostEmpty_q <= 1'b1;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wPtr_q        <= wPtr_d;
      rPtr_q        <= rPtr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      almostFull_q  <= almostFull_d;
      almostEmpty_q <= almostEmpty_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  assign w_addr       = wPtr_q;
  assign r_addr       = rPtr_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almostFull_q;
  assign almost_empty = almostEmpty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl_flex.sv
// Drives fifo_ctrl_flex (DEPTH=5, AF=4, AE=1) with directed and random traffic and
// compares every output against an occupancy/pointer model built from plain arithmetic.
module tb_fifo_ctrl_flex;

  localparam int Depth = 5;
  localparam int AfTh  = 4;
  localparam int AeTh  = 1;
  localparam int Aw    = $clog2(Depth);
  localparam int Cw    = $clog2(Depth + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clr = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic          w_en, r_en;
  logic [Aw-1:0] w_addr, r_addr;
  logic [Cw-1:0] count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int checkCount = 0;
  int failCount  = 0;

  // Reference state: how many entries are held and where the next write/read land.
  int mCount = 0;
  int mWptr  = 0;
  int mRptr  = 0;
  int mOvf   = 0;
  int mUnf   = 0;

  fifo_ctrl_flex #(
    .DEPTH(Depth),
    .AF_THRESH(AfTh),
    .AE_THRESH(AeTh)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .wr(wr),
    .rd(rd),
    .w_en(w_en),
    .r_en(r_en),
    .w_addr(w_addr),
    .r_addr(r_addr),
    .count(count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkRegistered(input string tag);
    checkOutput({tag, ":count"}, int'(count), mCount);
    checkOutput({tag, ":w_addr"}, int'(w_addr), mWptr);
    checkOutput({tag, ":r_addr"}, int'(r_addr), mRptr);
    checkOutput({tag, ":full"}, int'(full), int'(mCount == Depth));
    checkOutput({tag, ":empty"}, int'(empty), int'(mCount == 0));
    checkOutput({tag, ":almost_full"}, int'(almost_full), int'(mCount >= AfTh));
    checkOutput({tag, ":almost_empty"}, int'(almost_empty), int'(mCount <= AeTh));
    checkOutput({tag, ":overflow"}, int'(overflow), mOvf);
    checkOutput({tag, ":underflow"}, int'(underflow), mUnf);
  endtask

  // One clock of traffic: inputs change on the falling edge, handshakes are checked
  // before the rising edge, registered state is checked just after it.
  task automatic applyStimulus(input string tag, input bit wrV, input bit rdV,
                               input bit clrV, input bit rstV);
    bit expW, expR;
    @(negedge clk);
    wr    = wrV;
    rd    = rdV;
    clr   = clrV;
    reset = rstV;
    #1;
    expR = rdV && (mCount > 0) && !clrV;
    expW = wrV && !clrV && ((mCount < Depth) || rdV);
    if (!rstV) begin
      checkOutput({tag, ":w_en"}, int'(w_en), int'(expW));
      checkOutput({tag, ":r_en"}, int'(r_en), int'(expR));
    end
    @(posedge clk);
    #1;
    if (rstV || clrV) begin
      mCount = 0; mWptr = 0; mRptr = 0; mOvf = 0; mUnf = 0;
    end else begin
      if (expW) mWptr = (mWptr + 1) % Depth;
      if (expR) mRptr = (mRptr + 1) % Depth;
      mCount = mCount + int'(expW) - int'(expR);
      if (wrV && !expW) mOvf = 1;
      if (rdV && !expR) mUnf = 1;
    end
    checkRegistered(tag);
  endtask

  initial begin
    int pWr, pRd;
    applyStimulus("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("reset2", 1'b1, 1'b1, 1'b0, 1'b1);

    // Fill past full, then drain past empty.
    for (int i = 0; i < 6; i++) applyStimulus("fill", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus("drain", 1'b0, 1'b1, 1'b0, 1'b0);

    // Steady occupancy of 3 with simultaneous traffic wrapping both pointers.
    applyStimulus("clr0", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("to3", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus("steady", 1'b1, 1'b1, 1'b0, 1'b0);

    // Simultaneous access at both boundaries.
    applyStimulus("to4", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("to5", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("fullWrRd", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus("clr1", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("emptyWrRd", 1'b1, 1'b1, 1'b0, 1'b0);

    // Flush with requests pending and a sticky overflow set.
    applyStimulus("clr2", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("re3", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("ovfRd", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("fill5", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("drain3a", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("drain3b", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("clrBusy", 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus("afterClr", 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic; write/read bias shifts per phase so both boundaries are hit.
    for (int ph = 0; ph < 8; ph++) begin
      pWr = (ph % 2 == 0) ? 75 : 25;
      pRd = 100 - pWr;
      for (int i = 0; i < 60; i++) begin
        applyStimulus("rand",
                      ($urandom_range(99) < pWr),
                      ($urandom_range(99) < pRd),
                      ($urandom_range(39) == 0),
                      ($urandom_range(99) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
